// File: rtl/cam_serializer_fifo_if.sv
// Word-in / camera-port-out bundle of the FIFO-buffered camera-port serializer.
// master = producer side (writes words, watches status); slave = serializer.
interface cam_serializer_fifo_if #(
  parameter int DATA_WIDTH = 32,
  parameter int BUS_WIDTH  = 4,
  parameter int FIFO_DEPTH = 8
);
  localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

  logic                  wr_i;
  logic [DATA_WIDTH-1:0] data_i;
  logic                  clr_overflow_i;
  logic                  full;
  logic [LEVEL_W-1:0]    level;
  logic                  busy;
  logic                  overflow;
  logic                  cam_pclk;
  logic                  cam_sync;
  logic [BUS_WIDTH-1:0]  cam_data;

  modport master (
    output wr_i, data_i, clr_overflow_i,
    input  full, level, busy, overflow, cam_pclk, cam_sync, cam_data
  );

  modport slave (
    input  wr_i, data_i, clr_overflow_i,
    output full, level, busy, overflow, cam_pclk, cam_sync, cam_data
  );
endinterface

// File: rtl/cam_serializer_fifo.sv
// Word FIFO feeding an LSB-first camera-port serializer on a gated, divided PCLK.
// Optional macro CAM_SER_DRAIN_SYNC_EN: also mark EOF on the packet that drains the FIFO.
module cam_serializer_fifo #(
  parameter int DATA_WIDTH      = 32,
  parameter int BUS_WIDTH       = 4,
  parameter int FIFO_DEPTH      = 8,
  parameter int COUNT_WIDTH     = 2,
  parameter int SYNC_EVERY_PKTS = 400,
  parameter int PAD_BEATS       = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_n,
  cam_serializer_fifo_if.slave bus
);
  localparam int NB       = DATA_WIDTH / BUS_WIDTH;
  localparam int PKT_LEN  = NB + 1 + PAD_BEATS;
  localparam int BEAT_W   = $clog2(PKT_LEN);
  localparam int ADDR_W   = $clog2(FIFO_DEPTH);
  localparam int LEVEL_W  = ADDR_W + 1;
  localparam logic        CADENCE_ALWAYS = (SYNC_EVERY_PKTS <= 1);
  localparam logic [15:0] SYNC_LAST      = CADENCE_ALWAYS ? 16'd0 : 16'(SYNC_EVERY_PKTS - 1);

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  logic [DATA_WIDTH-1:0]  mem [FIFO_DEPTH];
  logic [ADDR_W-1:0]      wr_ptr_reg, rd_ptr_reg;
  logic [LEVEL_W-1:0]     count_reg;
  logic                   overflow_reg;
  logic [COUNT_WIDTH-1:0] div_reg;
  state_t                 state_reg;
  logic [BEAT_W-1:0]      beat_reg;
  logic [DATA_WIDTH-1:0]  shift_reg;
  logic                   sync_pkt_reg;
  logic [15:0]            pkt_cnt_reg;
  logic [BUS_WIDTH-1:0]   cam_data_reg;
  logic                   cam_sync_reg;

  logic                  full, push, tick, pkt_end, launch, sync_launch;
  logic [15:0]           pkt_cnt_next;
  logic [DATA_WIDTH-1:0] head_word, shift_next;

  // full reflects the registered count, so a write is judged before any same-cycle pop
  assign full       = (count_reg == LEVEL_W'(FIFO_DEPTH));
  assign push       = bus.wr_i & ~full;
  assign tick       = (div_reg == '0);
  assign pkt_end    = tick & (state_reg == S_ACTIVE) & (beat_reg == BEAT_W'(PKT_LEN - 1));
  assign launch     = tick & (count_reg != '0) & ((state_reg == S_IDLE) | pkt_end);
  assign head_word  = mem[rd_ptr_reg];
  assign shift_next = shift_reg >> BUS_WIDTH;

  // A back-to-back relaunch must see the count already updated by the packet just ending
  always_comb begin
    pkt_cnt_next = pkt_cnt_reg;
    if (pkt_end) begin
      pkt_cnt_next = sync_pkt_reg ? 16'd0 : pkt_cnt_reg + 16'd1;
    end
  end

`ifdef CAM_SER_DRAIN_SYNC_EN
  assign sync_launch = CADENCE_ALWAYS | (pkt_cnt_next == SYNC_LAST) | (count_reg == LEVEL_W'(1));
`else
  assign sync_launch = CADENCE_ALWAYS | (pkt_cnt_next == SYNC_LAST);
`endif

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr_reg] <= bus.data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      div_reg      <= '0;
    end else begin
      div_reg <= div_reg + 1'b1;
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (launch) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push & ~launch) begin
        count_reg <= count_reg + 1'b1;
      end else if (launch & ~push) begin
        count_reg <= count_reg - 1'b1;
      end
      if (bus.wr_i & full) begin
        overflow_reg <= 1'b1;
      end else if (bus.clr_overflow_i) begin
        overflow_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      beat_reg     <= '0;
      shift_reg    <= '0;
      sync_pkt_reg <= 1'b0;
      pkt_cnt_reg  <= '0;
      cam_data_reg <= '0;
      cam_sync_reg <= 1'b0;
    end else if (tick) begin
      pkt_cnt_reg <= pkt_cnt_next;
      if (launch) begin
        state_reg    <= S_ACTIVE;
        beat_reg     <= '0;
        shift_reg    <= head_word;
        sync_pkt_reg <= sync_launch;
        cam_data_reg <= head_word[BUS_WIDTH-1:0];
        cam_sync_reg <= 1'b0;
      end else if (pkt_end) begin
        state_reg    <= S_IDLE;
        beat_reg     <= '0;
        sync_pkt_reg <= 1'b0;
        cam_data_reg <= '0;
        cam_sync_reg <= 1'b0;
      end else if (state_reg == S_ACTIVE) begin
        beat_reg     <= beat_reg + 1'b1;
        shift_reg    <= shift_next;
        cam_data_reg <= (beat_reg < BEAT_W'(NB - 1)) ? shift_next[BUS_WIDTH-1:0] : '0;
        cam_sync_reg <= sync_pkt_reg & (beat_reg == BEAT_W'(NB - 1));
      end
    end
  end

  assign bus.full     = full;
  assign bus.level    = count_reg;
  assign bus.busy     = (state_reg == S_ACTIVE) | (count_reg != '0);
  assign bus.overflow = overflow_reg;
  assign bus.cam_pclk = (state_reg == S_ACTIVE) & div_reg[COUNT_WIDTH-1];
  assign bus.cam_sync = cam_sync_reg;
  assign bus.cam_data = cam_data_reg;
endmodule

// File: tb/tb_cam_serializer_fifo.sv
// Directed bench for cam_serializer_fifo: beat scoreboards per instance, sampled on PCLK rise.
module tb_cam_serializer_fifo;
  logic clk_i = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef CAM_SER_DRAIN_SYNC_EN
  localparam logic DRAIN = 1'b1;
`else
  localparam logic DRAIN = 1'b0;
`endif

  cam_serializer_fifo_if #(.DATA_WIDTH(32), .BUS_WIDTH(4), .FIFO_DEPTH(8)) if0 ();
  cam_serializer_fifo_if #(.DATA_WIDTH(32), .BUS_WIDTH(4), .FIFO_DEPTH(8)) if1 ();
  cam_serializer_fifo_if #(.DATA_WIDTH(16), .BUS_WIDTH(8), .FIFO_DEPTH(8)) if3 ();

  cam_serializer_fifo #(.DATA_WIDTH(32), .BUS_WIDTH(4), .FIFO_DEPTH(8), .COUNT_WIDTH(2),
                        .SYNC_EVERY_PKTS(400), .PAD_BEATS(1))
    u0 (.clk_i(clk_i), .rst_n(rst_n), .bus(if0));
  cam_serializer_fifo #(.DATA_WIDTH(32), .BUS_WIDTH(4), .FIFO_DEPTH(8), .COUNT_WIDTH(2),
                        .SYNC_EVERY_PKTS(3), .PAD_BEATS(1))
    u1 (.clk_i(clk_i), .rst_n(rst_n), .bus(if1));
  cam_serializer_fifo #(.DATA_WIDTH(16), .BUS_WIDTH(8), .FIFO_DEPTH(8), .COUNT_WIDTH(2),
                        .SYNC_EVERY_PKTS(1), .PAD_BEATS(0))
    u3 (.clk_i(clk_i), .rst_n(rst_n), .bus(if3));

  // Divider phase reference: the edge after tb_div reads 0 carries the falling tick
  logic [1:0] tb_div;
  always @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) tb_div <= 2'd0;
    else        tb_div <= tb_div + 2'd1;
  end

  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [8:0] q3[$];
  logic prev0 = 1'b0, prev1 = 1'b0, prev3 = 1'b0;
  logic chk0 = 1'b1;
  int rise0 = 0, since0 = 0, gapmax0 = 0, act0 = 0, rise1 = 0, rise3 = 0;
  logic [3:0] peak0 = 4'd0;
  logic full_seen0 = 1'b0;

  always @(negedge clk_i) begin
    logic [8:0] e, o;
    since0++;
    if (if0.level > peak0) peak0 = if0.level;
    if (if0.full) full_seen0 = 1'b1;
    if (if0.busy && if0.level == 4'd0) act0++;
    if (if0.cam_pclk && !prev0) begin
      rise0++;
      if (since0 > gapmax0) gapmax0 = since0;
      since0 = 0;
      if (chk0) begin
        n_tests++;
        o = {if0.cam_sync, 4'h0, if0.cam_data};
        e = (q0.size() > 0) ? q0.pop_front() : 9'h1FF;
        assert (o === e) else begin
          n_fail++;
          $error("FAIL u0_beat%0d observed %h required %h", rise0, o, e);
        end
      end
    end
    prev0 = if0.cam_pclk;
  end

  always @(negedge clk_i) begin
    logic [8:0] e, o;
    if (if1.cam_pclk && !prev1) begin
      rise1++;
      n_tests++;
      o = {if1.cam_sync, 4'h0, if1.cam_data};
      e = (q1.size() > 0) ? q1.pop_front() : 9'h1FF;
      assert (o === e) else begin
        n_fail++;
        $error("FAIL u1_beat%0d observed %h required %h", rise1, o, e);
      end
    end
    prev1 = if1.cam_pclk;
  end

  always @(negedge clk_i) begin
    logic [8:0] e, o;
    if (if3.cam_pclk && !prev3) begin
      rise3++;
      n_tests++;
      o = {if3.cam_sync, if3.cam_data};
      e = (q3.size() > 0) ? q3.pop_front() : 9'h1FF;
      assert (o === e) else begin
        n_fail++;
        $error("FAIL u3_beat%0d observed %h required %h", rise3, o, e);
      end
    end
    prev3 = if3.cam_pclk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // 32-bit word on a 4-bit bus: 8 nibbles LSB-first, sync beat, one pad beat
  task automatic exp_pkt4(input int which, input logic [31:0] w, input logic s);
    logic [8:0] e;
    for (int b = 0; b < 10; b++) begin
      if (b < 8)       e = {5'b0, w[4*b +: 4]};
      else if (b == 8) e = {s, 8'h00};
      else             e = 9'h000;
      if (which == 0) q0.push_back(e);
      else            q1.push_back(e);
    end
  endtask

  task automatic put(input int which, input logic [31:0] w, input logic s, input logic accepted);
    case (which)
      0: begin
        if0.wr_i = 1'b1; if0.data_i = w;
        if (accepted) exp_pkt4(0, w, s);
      end
      1: begin
        if1.wr_i = 1'b1; if1.data_i = w;
        if (accepted) exp_pkt4(1, w, s);
      end
      default: begin
        if3.wr_i = 1'b1; if3.data_i = w[15:0];
        if (accepted) begin
          q3.push_back({1'b0, w[7:0]});
          q3.push_back({1'b0, w[15:8]});
          q3.push_back({s, 8'h00});
        end
      end
    endcase
    @(negedge clk_i);
  endtask

  task automatic stop_wr();
    if0.wr_i = 1'b0; if1.wr_i = 1'b0; if3.wr_i = 1'b0;
  endtask

  task automatic align();
    do @(negedge clk_i); while (tb_div != 2'd1);
  endtask

  task automatic wait_idle(input int which, input int max_cyc, input string tag);
    int n = 0;
    logic b;
    do begin
      @(negedge clk_i);
      n++;
      b = (which == 0) ? if0.busy : (which == 1) ? if1.busy : if3.busy;
    end while (b && n < max_cyc);
    chk({tag, "_busy_timeout"}, 32'(b), 32'd0);
  endtask

  function automatic logic [31:0] outs0();
    return 32'({if0.cam_pclk, if0.cam_sync, if0.cam_data, if0.busy, if0.full, if0.overflow, if0.level});
  endfunction

  initial begin
    int r;
    logic [31:0] w;
    if0.wr_i = 1'b0; if0.data_i = '0; if0.clr_overflow_i = 1'b0;
    if1.wr_i = 1'b0; if1.data_i = '0; if1.clr_overflow_i = 1'b0;
    if3.wr_i = 1'b0; if3.data_i = '0; if3.clr_overflow_i = 1'b0;

    repeat (3) @(negedge clk_i);
    chk("reset_outputs", outs0(), 32'd0);
    rst_n = 1'b1;
    @(negedge clk_i);
    chk("post_reset_outputs", outs0(), 32'd0);

    // Single word while idle
    act0 = 0;
    r = rise0;
    put(0, 32'h87654321, DRAIN, 1'b1);
    stop_wr();
    chk("single_level", 32'(if0.level), 32'd1);
    chk("single_busy", 32'(if0.busy), 32'd1);
    wait_idle(0, 100, "single");
    chk("single_beats", 32'(rise0 - r), 32'd10);
    chk("single_active_cycles", 32'(act0), 32'd40);
    chk("single_pclk_idle", 32'(if0.cam_pclk), 32'd0);
    chk("single_data_idle", 32'(if0.cam_data), 32'd0);
    chk("single_queue_empty", 32'(q0.size()), 32'd0);

    // Burst of 8 back-to-back packets
    align();
    peak0 = 4'd0;
    full_seen0 = 1'b0;
    r = rise0;
    for (int i = 0; i < 8; i++) begin
      w = $urandom();
      put(0, w, DRAIN && i == 7, 1'b1);
    end
    stop_wr();
    for (int n = 0; n < 20 && rise0 == r; n++) @(negedge clk_i);
    gapmax0 = 0;
    wait_idle(0, 500, "burst");
    chk("burst_peak_level", 32'(peak0), 32'd7);
    chk("burst_full_seen", 32'(full_seen0), 32'd0);
    chk("burst_overflow", 32'(if0.overflow), 32'd0);
    chk("burst_pclk_gap", 32'(gapmax0), 32'd4);
    chk("burst_queue_empty", 32'(q0.size()), 32'd0);

    // Overflow: 10 writes, the 10th dropped
    align();
    for (int i = 0; i < 10; i++) begin
      w = 32'h1000_0000 + 32'(i) * 32'h0123_4567;
      put(0, w, DRAIN && i == 8, i < 9);
    end
    stop_wr();
    chk("ovf_flag_set", 32'(if0.overflow), 32'd1);
    chk("ovf_level_full", 32'(if0.level), 32'd8);
    chk("ovf_full", 32'(if0.full), 32'd1);
    if0.clr_overflow_i = 1'b1;
    @(negedge clk_i);
    if0.clr_overflow_i = 1'b0;
    chk("ovf_cleared", 32'(if0.overflow), 32'd0);
    chk("ovf_full_before_collision", 32'(if0.full), 32'd1);
    if0.wr_i = 1'b1; if0.data_i = 32'hDEAD_BEEF; if0.clr_overflow_i = 1'b1;
    @(negedge clk_i);
    if0.wr_i = 1'b0; if0.clr_overflow_i = 1'b0;
    chk("ovf_set_beats_clear", 32'(if0.overflow), 32'd1);
    chk("ovf_level_after_drop", 32'(if0.level), 32'd8);
    if0.clr_overflow_i = 1'b1;
    @(negedge clk_i);
    if0.clr_overflow_i = 1'b0;
    chk("ovf_cleared_again", 32'(if0.overflow), 32'd0);
    wait_idle(0, 600, "ovf");
    chk("ovf_queue_empty", 32'(q0.size()), 32'd0);

    // Three-word burst: EOF only on the draining packet when the drain option is built in
    align();
    for (int i = 0; i < 3; i++) put(0, 32'hABC0_0000 + 32'(i), DRAIN && i == 2, 1'b1);
    stop_wr();
    wait_idle(0, 200, "drain3");
    chk("drain3_queue_empty", 32'(q0.size()), 32'd0);

    // Reset in the middle of beat 4
    chk0 = 1'b0;
    r = rise0;
    put(0, 32'hCAFE_F00D, 1'b0, 1'b0);
    stop_wr();
    for (int n = 0; n < 100 && rise0 < r + 5; n++) @(negedge clk_i);
    chk("midrst_reached_beat4", 32'(rise0 - r), 32'd5);
    #2 rst_n = 1'b0;
    #1 chk("midrst_outputs_zero", outs0(), 32'd0);
    @(negedge clk_i);
    rst_n = 1'b1;
    chk0 = 1'b1;
    put(0, 32'h0000_0001, DRAIN, 1'b1);
    stop_wr();
    wait_idle(0, 100, "midrst_resend");
    chk("midrst_queue_empty", 32'(q0.size()), 32'd0);

    // Cadence of 3: EOF on packets 3 and 6
    align();
    for (int i = 0; i < 7; i++) begin
      w = $urandom();
      put(1, w, (i == 2) || (i == 5) || (DRAIN && i == 6), 1'b1);
    end
    stop_wr();
    wait_idle(1, 400, "cadence");
    chk("cadence_queue_empty", 32'(q1.size()), 32'd0);

    // 16-bit word on an 8-bit bus, no pad, EOF every packet
    align();
    put(2, 32'h0000_BEEF, 1'b1, 1'b1);
    put(2, 32'h0000_1234, 1'b1, 1'b1);
    stop_wr();
    wait_idle(2, 100, "width");
    chk("width_queue_empty", 32'(q3.size()), 32'd0);
    chk("width_data_idle", 32'(if3.cam_data), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/cam_serializer_fifo.md
Name: cam_serializer_fifo

Overview:
- Parametrised successor to the single-word ESP32 camera-port serializer.
- Buffers up to FIFO_DEPTH words and serialises each as a packet of BUS_WIDTH-bit beats on a gated PCLK.
- Generalises word width, bus width, pad length and queue depth, and flags overflow with a clearable sticky flag.
- Sits between the FPGA event/capture logic and the ESP32 camera (LCD_CAM) input.

Parameters:
- DATA_WIDTH, 32: payload word width; must be a multiple of BUS_WIDTH.
- BUS_WIDTH, 4: cam_data width; 1, 2, 4 or 8.
- FIFO_DEPTH, 8: word queue depth; power of 2, at least 2.
- COUNT_WIDTH, 2: free-running divider width; PCLK period is 2^COUNT_WIDTH clk_i cycles.
- SYNC_EVERY_PKTS, 400: cam_sync cadence in packets; a value of 1 or less means every packet.
- PAD_BEATS, 1: idle beats after the sync beat; range 0..15.

Ports:
- clk_i  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- wr_i  in  1  write strobe, one word per cycle
- data_i  in  DATA_WIDTH  word to enqueue
- clr_overflow_i  in  1  clears the overflow flag
- full  out  1  FIFO full; a write this cycle is dropped
- level  out  $clog2(FIFO_DEPTH)+1  number of queued words, excluding the word in flight
- busy  out  1  packet active OR level != 0
- overflow  out  1  sticky dropped-write flag
- cam_pclk  out  1  gated PCLK
- cam_sync  out  1  VSYNC/EOF marker
- cam_data  out  BUS_WIDTH  data beat

Behaviour:
- Reset (async): FIFO empty, level=0, full=0, overflow=0, busy=0, cam_pclk=0, cam_sync=0, cam_data=0, divider=0, packet counter=0, state IDLE.
- Reset asserted mid-packet aborts the packet immediately; cam_pclk goes low the same instant.
- FIFO write:
  - wr_i & !full pushes data_i; the word is counted in level on the next cycle.
  - wr_i & full drops the word and sets overflow.
  - full is evaluated before any same-cycle pop, so a write while full is dropped even if a pop occurs that cycle.
  - A simultaneous push and pop leaves level unchanged.
- Overflow flag: clr_overflow_i clears it; if a set and a clear occur in the same cycle, the set wins.
- Divider:
  - Free-running counter div.
  - pclk_int = div MSB.
  - The falling tick is div==0; every beat change happens only on this tick.
- cam_pclk: equals pclk_int while in ACTIVE, otherwise 0.
- Packet length: NB = DATA_WIDTH/BUS_WIDTH data beats, then 1 sync beat, then PAD_BEATS pad beats; total L = NB+1+PAD_BEATS.
- State machine (beat counter advances only on the falling tick):
  - IDLE to ACTIVE: on a falling tick with level != 0.
    - Pop the head word into the shift register; beat=0.
    - Latch sync_pkt (rule below).
  - ACTIVE:
    - Each falling tick shifts the word right by BUS_WIDTH (LSB-first) and increments beat.
    - cam_data = shift[BUS_WIDTH-1:0] for beats 0..NB-1, and 0 for the sync and pad beats.
  - Final beat (beat==L-1) at a falling tick:
    - Update the packet counter.
    - If level != 0, pop and restart at beat 0 with no idle PCLK period (back-to-back).
    - Otherwise go to IDLE with cam_data=0.
- cam_sync: = ACTIVE & (beat==NB) & sync_pkt.
- Sync gating:
  - pkt_cnt is 16 bits.
  - At launch, sync_pkt = (SYNC_EVERY_PKTS<=1) | (pkt_cnt==SYNC_EVERY_PKTS-1).
  - At packet end, pkt_cnt resets to 0 if sync_pkt was set, otherwise increments.
- Launch latency: a write at cycle t is launched at the first falling tick at or after t+1, provided the FIFO was empty and the serializer idle.

Optional Feature:
- Macro: CAM_SER_DRAIN_SYNC_EN
- With the macro defined:
  - A packet launched while level==1 (FIFO empties on this pop) also sets sync_pkt.
  - The ESP32 therefore gets an EOF as soon as a burst drains, not only on the cadence.
  - pkt_cnt resets after such a packet.
- Without the macro: sync is driven purely by the cadence counter.

Test Plan:
- Single word, defaults: write 0x87654321 while idle.
  - Required response: one packet of 10 beats, 40 clk_i cycles.
  - cam_data nibbles on successive PCLK rising edges: 1,2,3,4,5,6,7,8,0,0.
  - cam_sync low (cadence not reached).
  - cam_pclk then stops low; busy falls.
- Burst: write 8 words in consecutive cycles.
  - Required response: level peaks at 7.
  - No overflow, full never asserts.
  - 8 packets back-to-back with continuous PCLK and no gap cycles.
- Overflow: 10 writes in consecutive cycles.
  - Required response: the 10th is dropped (full), overflow=1.
  - 9 packets are transmitted.
  - clr_overflow_i pulse gives overflow=0; a clear coincident with a dropped write leaves overflow=1.
- Cadence: SYNC_EVERY_PKTS=3, send 7 packets.
  - Required response: cam_sync pulses (one PCLK period, beat 8) on packets 3 and 6 only.
  - With SYNC_EVERY_PKTS=1, the pulse appears on every packet.
- Width variant: DATA_WIDTH=16, BUS_WIDTH=8, PAD_BEATS=0, word 0xBEEF.
  - Required response: beats EF, BE, then a sync beat of 00; 3 beats total.
- Reset mid-packet at beat 4.
  - Required response: all outputs 0 immediately, level=0.
  - A subsequent write of 0x1 transmits cleanly with beats 1,0,...
- With CAM_SER_DRAIN_SYNC_EN defined, write 3 words.
  - Required response: only the 3rd packet asserts cam_sync.
